// File: rtl/fp_format_pkg.sv
// Shared constants for the internal floating-point word and its IEEE-754 packing:
// exception codes, field widths, the canonical quiet NaN and sticky flag positions.
package fp_format_pkg;

    localparam int SIZE_MANTISSA        = 24;
    localparam int SIZE_EXPONENT        = 8;
    localparam int SIZE_EXCEPTION_FIELD = 2;
    localparam int SIZE_IN              = SIZE_MANTISSA + SIZE_EXPONENT + SIZE_EXCEPTION_FIELD;
    localparam int SIZE_OUT             = SIZE_MANTISSA + SIZE_EXPONENT;

    typedef enum logic [1:0] {
        EXC_ZERO          = 2'd0,
        EXC_NORMAL_NUMBER = 2'd1,
        EXC_INFINITY      = 2'd2,
        EXC_NAN           = 2'd3
    } exception_e;

    localparam logic [31:0] CANON_QNAN = 32'h7FC0_0000;

    localparam int NUM_FLAGS      = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 0;

endpackage

// File: rtl/fp_ieee_encode_comb.sv
// Combinational conversion of one internal floating-point word to an IEEE-754 word,
// with the per-word overflow / underflow / inexact events it raises.
module fp_ieee_encode_comb
    import fp_format_pkg::*;
#(
    parameter int size_mantissa        = SIZE_MANTISSA,
    parameter int size_exponent        = SIZE_EXPONENT,
    parameter int size_exception_field = SIZE_EXCEPTION_FIELD,
    localparam int size_in             = size_mantissa + size_exponent + size_exception_field,
    localparam int size_out            = size_mantissa + size_exponent
) (
    input  logic [size_in-1:0]  number,
    output logic [size_out-1:0] ieee,
    output logic                overflow,
    output logic                underflow,
    output logic                inexact
);

    localparam int FW = size_mantissa - 1;

    logic [size_exception_field-1:0] exc_s;
    logic                            sign_s;
    logic [size_exponent-1:0]        exp_s;
    logic [FW-1:0]                   frac_s;
    logic [FW-1:0]                   sub_frac_s;
    logic                            guard_s;
    logic [size_out-2:0]             sub_mag_s;

    assign exc_s  = number[size_in-1 -: size_exception_field];
    assign sign_s = number[size_out-1];
    assign exp_s  = number[size_out-2 -: size_exponent];
    assign frac_s = number[FW-1:0];

    // 1.f x 2^(1-bias-1) becomes 0.1f x 2^(1-bias): shift the hidden bit in, keep f[0] as guard.
    assign sub_frac_s = {1'b1, frac_s[FW-1:1]};
    assign guard_s    = frac_s[0];
    // Tie-to-even increment; a carry out of the fraction lands in the exponent as 1.
    assign sub_mag_s  = {{size_exponent{1'b0}}, sub_frac_s}
                      + {{(size_out-2){1'b0}}, (guard_s & sub_frac_s[0])};

    // Select the IEEE encoding and event bits by exception class.
    always_comb begin
        ieee      = '0;
        overflow  = 1'b0;
        underflow = 1'b0;
        inexact   = 1'b0;
        case (exc_s)
            EXC_ZERO: begin
                ieee = {sign_s, {(size_out-1){1'b0}}};
            end
            EXC_INFINITY: begin
                ieee = {sign_s, {size_exponent{1'b1}}, {FW{1'b0}}};
            end
            EXC_NAN: begin
                ieee = {1'b0, {size_exponent{1'b1}}, 1'b1, {(FW-1){1'b0}}};
            end
            EXC_NORMAL_NUMBER: begin
                if (exp_s == {size_exponent{1'b1}}) begin
                    ieee     = {sign_s, {size_exponent{1'b1}}, {FW{1'b0}}};
                    overflow = 1'b1;
                    inexact  = 1'b1;
                end else if (exp_s == {size_exponent{1'b0}}) begin
                    ieee      = {sign_s, sub_mag_s};
                    underflow = 1'b1;
                    inexact   = guard_s;
                end else begin
                    ieee = {sign_s, exp_s, frac_s};
                end
            end
            default: begin
                ieee = '0;
            end
        endcase
    end

endmodule

// File: rtl/fp_ieee_packer.sv
// Two-stage valid/ready pipeline packing internal floating-point words into IEEE-754 words,
// accumulating sticky overflow / underflow / inexact flags as words enter the output stage.
module fp_ieee_packer
    import fp_format_pkg::*;
#(
    parameter int size_mantissa        = SIZE_MANTISSA,
    parameter int size_exponent        = SIZE_EXPONENT,
    parameter int size_exception_field = SIZE_EXCEPTION_FIELD,
    localparam int size_in             = size_mantissa + size_exponent + size_exception_field,
    localparam int size_out            = size_mantissa + size_exponent
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [size_in-1:0]   number_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [size_out-1:0]  ieee_o,
    input  logic                 clear_flags_i,
    output logic [NUM_FLAGS-1:0] flags_o
);

    logic [size_out-1:0]  enc_word_s;
    logic [NUM_FLAGS-1:0] enc_events_s;
    logic                 enc_overflow_s;
    logic                 enc_underflow_s;
    logic                 enc_inexact_s;

    logic                 s1_valid_r;
    logic [size_out-1:0]  s1_word_r;
    logic [NUM_FLAGS-1:0] s1_events_r;
    logic                 s2_valid_r;
    logic [size_out-1:0]  s2_word_r;
    logic [NUM_FLAGS-1:0] flags_r;

    logic                 s2_adv_s;
    logic                 s1_adv_s;
    logic                 in_accept_s;
    logic                 s1_move_s;

    fp_ieee_encode_comb #(
        .size_mantissa        (size_mantissa),
        .size_exponent        (size_exponent),
        .size_exception_field (size_exception_field)
    ) u_encode (
        .number    (number_i),
        .ieee      (enc_word_s),
        .overflow  (enc_overflow_s),
        .underflow (enc_underflow_s),
        .inexact   (enc_inexact_s)
    );

    assign enc_events_s[FLAG_OVERFLOW]  = enc_overflow_s;
    assign enc_events_s[FLAG_UNDERFLOW] = enc_underflow_s;
    assign enc_events_s[FLAG_INEXACT]   = enc_inexact_s;

    assign s2_adv_s    = !s2_valid_r || out_ready_i;
    assign s1_adv_s    = !s1_valid_r || s2_adv_s;
    assign in_accept_s = in_valid_i && s1_adv_s;
    assign s1_move_s   = s1_valid_r && s2_adv_s;

    // Stage 1: capture the encoded word and its events.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r  <= 1'b0;
            s1_word_r   <= '0;
            s1_events_r <= '0;
        end else if (s1_adv_s) begin
            s1_valid_r <= in_valid_i;
            if (in_accept_s) begin
                s1_word_r   <= enc_word_s;
                s1_events_r <= enc_events_s;
            end
        end
    end

    // Stage 2: output register, held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_r <= 1'b0;
            s2_word_r  <= '0;
        end else if (s2_adv_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_word_r <= s1_word_r;
            end
        end
    end

    // Sticky flags: a clear coinciding with new events keeps only the new events.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_r <= '0;
        end else if (s1_move_s) begin
            flags_r <= clear_flags_i ? s1_events_r : (flags_r | s1_events_r);
        end else if (clear_flags_i) begin
            flags_r <= '0;
        end
    end

    assign in_ready_o  = s1_adv_s;
    assign out_valid_o = s2_valid_r;
    assign ieee_o      = s2_word_r;
    assign flags_o     = flags_r;

endmodule

// File: tb/tb_fp_ieee_packer.sv
// Directed self-checking bench for fp_ieee_packer: conversions, flags, backpressure and reset.
module tb_fp_ieee_packer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [33:0] number_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ieee;
    logic        clear_flags;
    logic [2:0]  flags;

    int n_checks;
    int n_errors;

    logic [33:0] bp_in  [8];
    logic [31:0] bp_exp [8];

    fp_ieee_packer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .number_i      (number_in),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .ieee_o        (ieee),
        .clear_flags_i (clear_flags),
        .flags_o       (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Push one word with out_ready high and check it at the expected two-cycle latency.
    task automatic push_and_check(input string tag, input logic [33:0] num,
                                  input logic [31:0] exp_word, input logic [2:0] exp_flags);
        int n;
        in_valid  = 1'b1;
        number_in = num;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 8) begin
            @(negedge clk);
            n++;
        end
        check_value({tag, "_valid"}, 32'(out_valid), 32'd1);
        check_value({tag, "_latency"}, 32'(n), 32'd1);
        check_value({tag, "_word"}, ieee, exp_word);
        check_value({tag, "_flags"}, 32'(flags), 32'(exp_flags));
    endtask

    initial begin
        int sent;
        int recv;
        int stall_cnt;
        int stale;

        n_checks    = 0;
        n_errors    = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        number_in   = 34'h0;
        out_ready   = 1'b1;
        clear_flags = 1'b0;

        bp_in[0] = 34'h1_3F80_0000;  bp_exp[0] = 32'h3F80_0000;
        bp_in[1] = 34'h1_4000_0001;  bp_exp[1] = 32'h4000_0001;
        bp_in[2] = 34'h1_C120_0002;  bp_exp[2] = 32'hC120_0002;
        bp_in[3] = 34'h1_4240_0003;  bp_exp[3] = 32'h4240_0003;
        bp_in[4] = 34'h1_BF00_0004;  bp_exp[4] = 32'hBF00_0004;
        bp_in[5] = 34'h1_4480_0005;  bp_exp[5] = 32'h4480_0005;
        bp_in[6] = 34'h1_4500_0006;  bp_exp[6] = 32'h4500_0006;
        bp_in[7] = 34'h1_C580_0007;  bp_exp[7] = 32'hC580_0007;

        repeat (3) @(negedge clk);
        check_value("rst_valid", 32'(out_valid), 32'd0);
        check_value("rst_word", ieee, 32'h0);
        check_value("rst_flags", 32'(flags), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_value("rst_in_ready", 32'(in_ready), 32'd1);

        push_and_check("norm_1p0", 34'h1_3F80_0000, 32'h3F80_0000, 3'b000);
        push_and_check("norm_m2p5", 34'h1_C020_0000, 32'hC020_0000, 3'b000);
        push_and_check("neg_inf", 34'h2_8000_0000, 32'hFF80_0000, 3'b000);
        push_and_check("nan", 34'h3_ABCD_1234, 32'h7FC0_0000, 3'b000);
        push_and_check("neg_zero", 34'h0_8000_0000, 32'h8000_0000, 3'b000);

        push_and_check("sub_3", 34'h1_0000_0003, 32'h0040_0002, 3'b011);
        push_and_check("sub_tie", 34'h1_0000_0001, 32'h0040_0000, 3'b011);
        push_and_check("sub_carry", 34'h1_007F_FFFF, 32'h0080_0000, 3'b011);

        clear_flags = 1'b1;
        @(posedge clk);
        #1;
        clear_flags = 1'b0;
        @(negedge clk);
        check_value("clear_pulse", 32'(flags), 32'd0);

        push_and_check("ovf", 34'h1_7F80_0000, 32'h7F80_0000, 3'b101);
        push_and_check("ovf_then_sub", 34'h1_0000_0003, 32'h0040_0002, 3'b111);

        // Clear lands on the same edge the overflow word moves into stage 2.
        in_valid  = 1'b1;
        number_in = 34'h1_7F80_0000;
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        clear_flags = 1'b1;
        @(posedge clk);
        #1;
        clear_flags = 1'b0;
        @(negedge clk);
        check_value("clr_coincide_valid", 32'(out_valid), 32'd1);
        check_value("clr_coincide_word", ieee, 32'h7F80_0000);
        check_value("clr_coincide_flags", 32'(flags), 32'(3'b101));

        // Backpressure: stream 8 words, consumer stalls in loop cycles 3..6.
        sent = 0;
        recv = 0;
        stall_cnt = 0;
        @(posedge clk);
        for (int c = 0; c < 40 && recv < 8; c++) begin
            #1;
            out_ready = !(c >= 3 && c <= 6);
            in_valid  = (sent < 8);
            number_in = bp_in[(sent < 8) ? sent : 0];
            #1;
            if (in_valid && !in_ready) stall_cnt++;
            if (out_valid) begin
                check_value(out_ready ? "bp_word" : "bp_hold", ieee, bp_exp[recv]);
                if (out_ready) recv++;
            end
            if (in_valid && in_ready) sent++;
            @(posedge clk);
        end
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check_value("bp_received", 32'(recv), 32'd8);
        check_value("bp_in_ready_low", 32'(stall_cnt), 32'd4);
        check_value("bp_flags", 32'(flags), 32'(3'b101));

        // Reset with two words in flight.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        number_in = 34'h1_7F80_0000;
        @(posedge clk);
        #1;
        number_in = 34'h1_3F80_0000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check_value("inflight_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check_value("midrst_valid", 32'(out_valid), 32'd0);
        check_value("midrst_flags", 32'(flags), 32'd0);
        check_value("midrst_word", ieee, 32'h0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        stale = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check_value("post_rst_stale", 32'(stale), 32'd0);
        check_value("post_rst_in_ready", 32'(in_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
